// File: rtl/rpm_pkg.sv
// rpm_pkg: widths, blip FSM states and phase helpers shared by the
// blip generator and the RPM calculator. No ports.
package rpm_pkg;

  localparam int RPM_W = 10;
  localparam int NUM_W = 33;
  localparam int DEN_W = 17;
  localparam int PER_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } blip_state_t;

  // Odd periods put the spare clock in the low phase.
  function automatic logic [PER_W-1:0] hi_of(
    input logic [PER_W-1:0] p
  );
    return p >> 1;
  endfunction

  function automatic logic [PER_W-1:0] lo_of(
    input logic [PER_W-1:0] p
  );
    return p - (p >> 1);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per clock.
// Ports: clk, rst_n, start, dividend, divisor -> busy, done (pulse), quotient.
module seq_divider
  import rpm_pkg::*;
#(
  parameter int DIVD_W = NUM_W,
  parameter int DIVS_W = DEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIVD_W-1:0] dividend,
  input  logic [DIVS_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DIVD_W-1:0] quotient
);

  localparam int CW = $clog2(DIVD_W + 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DIVS_W-1:0] rem_q, rem_d;
  logic [DIVS_W-1:0] den_q, den_d;
  logic [DIVD_W-1:0] quo_q, quo_d;
  logic              done_q, done_d;
  logic [DIVS_W:0]   trial;

  // Divisor 0 makes every trial succeed: all-ones quotient.
  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    den_d  = den_q;
    quo_d  = quo_q;
    done_d = 1'b0;
    trial  = {rem_q, quo_q[DIVD_W-1]};
    if (start) begin
      cnt_d = CW'(DIVD_W);
      rem_d = '0;
      den_d = divisor;
      quo_d = dividend;
    end else if (cnt_q != '0) begin
      if (trial >= {1'b0, den_q}) begin
        rem_d = DIVS_W'(trial - {1'b0, den_q});
        quo_d = {quo_q[DIVD_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DIVS_W-1:0];
        quo_d = {quo_q[DIVD_W-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CW'(1);
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      quo_q  <= quo_d;
      done_q <= done_d;
    end
  end

  assign busy     = (cnt_q != '0);
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/rpm_blip_gen.sv
// rpm_blip_gen: RPM command -> blips square wave, one period per pole change.
// Ports: clk50M, reset_n, rpm_cmd, cmd_valid -> cmd_ready, blips, running
// (+ blip_count when BLIP_COUNT_EN is defined).
module rpm_blip_gen
  import rpm_pkg::*;
#(
  parameter int unsigned CLKSPEED   = 50000000,
  parameter int unsigned POLES      = 16,
  parameter int unsigned GEAR_RATIO = 5,
  parameter int unsigned MIN_PERIOD = 2
) (
  input  logic             clk50M,
  input  logic             reset_n,
  input  logic [RPM_W-1:0] rpm_cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             blips,
  output logic             running
`ifdef BLIP_COUNT_EN
  ,
  output logic [15:0]      blip_count
`endif
);

  localparam logic [NUM_W-1:0] DIVIDEND =
    NUM_W'(64'(CLKSPEED) * 64'd60);
  localparam logic [DEN_W-1:0] DEN_MUL =
    DEN_W'(POLES * GEAR_RATIO);
  localparam logic [PER_W-1:0] MIN_P = PER_W'(MIN_PERIOD);

  blip_state_t      state_q, state_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] active_q, active_d;
  logic [PER_W-1:0] pending_q, pending_d;
  logic             pend_v_q, pend_v_d;
  logic             blips_q, blips_d;
  logic             ready_q, ready_d;
  logic             run_q, run_d;
`ifdef BLIP_COUNT_EN
  logic [15:0]      bcnt_q, bcnt_d;
`endif

  logic             accept, stop, start;
  logic             div_busy, div_done;
  logic [NUM_W-1:0] div_q;
  logic [DEN_W-1:0] divisor;
  logic [PER_W-1:0] div_per, new_per, nxt_per;

  assign accept  = cmd_valid && ready_q;
  assign stop    = accept && (rpm_cmd == '0);
  assign start   = accept && (rpm_cmd != '0) && !div_busy;
  assign divisor = DEN_W'(rpm_cmd) * DEN_MUL;

  seq_divider #(
    .DIVD_W(NUM_W),
    .DIVS_W(DEN_W)
  ) u_div (
    .clk     (clk50M),
    .rst_n   (reset_n),
    .start   (start),
    .dividend(DIVIDEND),
    .divisor (divisor),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_q)
  );

  // Quotient above PER_W bits saturates rather than wrapping short.
  assign div_per = div_q[NUM_W-1] ? '1 : div_q[PER_W-1:0];
  assign new_per = (div_per < MIN_P) ? MIN_P : div_per;
  assign nxt_per = pend_v_q ? pending_q : active_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    blips_d   = blips_q;
    ready_d   = ready_q;
`ifdef BLIP_COUNT_EN
    bcnt_d    = bcnt_q;
`endif
    if (stop) begin
      state_d  = IDLE;
      cnt_d    = '0;
      pend_v_d = 1'b0;
      blips_d  = 1'b0;
`ifdef BLIP_COUNT_EN
      bcnt_d   = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pend_v_q) begin
            active_d = pending_q;
            pend_v_d = 1'b0;
            blips_d  = 1'b1;
            state_d  = HIGH;
            cnt_d    = hi_of(pending_q) - PER_W'(1);
`ifdef BLIP_COUNT_EN
            bcnt_d   = bcnt_q + 16'd1;
`endif
          end
        end
        HIGH: begin
          if (cnt_q == '0) begin
            blips_d = 1'b0;
            state_d = LOW;
            cnt_d   = lo_of(active_q) - PER_W'(1);
          end else begin
            cnt_d = cnt_q - PER_W'(1);
          end
        end
        LOW: begin
          // Period boundary: the only place a new speed is adopted.
          if (cnt_q == '0) begin
            active_d = nxt_per;
            pend_v_d = 1'b0;
            blips_d  = 1'b1;
            state_d  = HIGH;
            cnt_d    = hi_of(nxt_per) - PER_W'(1);
`ifdef BLIP_COUNT_EN
            bcnt_d   = bcnt_q + 16'd1;
`endif
          end else begin
            cnt_d = cnt_q - PER_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (start) begin
      ready_d = 1'b0;
    end
    // A result landing on a boundary waits for the following one.
    if (div_done) begin
      pending_d = new_per;
      pend_v_d  = 1'b1;
      ready_d   = 1'b1;
    end
    run_d = (state_d != IDLE);
  end

  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
      blips_q   <= 1'b0;
      ready_q   <= 1'b1;
      run_q     <= 1'b0;
`ifdef BLIP_COUNT_EN
      bcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_v_q  <= pend_v_d;
      blips_q   <= blips_d;
      ready_q   <= ready_d;
      run_q     <= run_d;
`ifdef BLIP_COUNT_EN
      bcnt_q    <= bcnt_d;
`endif
    end
  end

  assign cmd_ready = ready_q;
  assign blips     = blips_q;
  assign running   = run_q;
`ifdef BLIP_COUNT_EN
  assign blip_count = bcnt_q;
`endif

endmodule
